// File: rtl/slot_dispatcher.sv
// Slot-table DMA dispatcher: walks slots 0..count-1, issues a DMA command for each
// READY slot, waits for completion and writes back status plus a cycle profile.
module slot_dispatcher #(
  parameter int INDEX_WIDTH   = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 26,
  parameter int STATUS_WIDTH  = 2,
  parameter int PROFILE_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [INDEX_WIDTH:0]     slot_count,
  input  logic                     abort,
  output logic [INDEX_WIDTH-1:0]   rd_index,
  input  logic [ADDR_WIDTH-1:0]    rd_src_addr,
  input  logic [ADDR_WIDTH-1:0]    rd_des_addr,
  input  logic [SIZE_WIDTH-1:0]    rd_src_size,
  input  logic [SIZE_WIDTH-1:0]    rd_des_size,
  input  logic [STATUS_WIDTH-1:0]  rd_status,
  output logic [INDEX_WIDTH-1:0]   wr_index,
  output logic [STATUS_WIDTH-1:0]  wr_status,
  output logic [PROFILE_WIDTH-1:0] wr_profile,
  output logic                     set_status,
  output logic                     set_profile,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_WIDTH-1:0]    cmd_src_addr,
  output logic [ADDR_WIDTH-1:0]    cmd_des_addr,
  output logic [SIZE_WIDTH-1:0]    cmd_src_size,
  output logic [SIZE_WIDTH-1:0]    cmd_des_size,
  input  logic                     dma_done,
  input  logic                     dma_err,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_NEXT
  } state_t;

  localparam logic [STATUS_WIDTH-1:0] ST_READY = STATUS_WIDTH'(1);
  localparam logic [STATUS_WIDTH-1:0] ST_DONE  = STATUS_WIDTH'(2);
  localparam logic [STATUS_WIDTH-1:0] ST_ERROR = STATUS_WIDTH'(3);
  localparam logic [INDEX_WIDTH:0]    SLOTS    = {1'b1, {INDEX_WIDTH{1'b0}}};

  state_t                   r_state;
  state_t                   w_next;
  logic [INDEX_WIDTH-1:0]   r_idx;
  logic [INDEX_WIDTH:0]     r_count;
  logic [INDEX_WIDTH:0]     w_count_clamped;
  logic                     r_abort;
  logic                     r_zero_done;
  logic [PROFILE_WIDTH-1:0] r_profile;
  logic [STATUS_WIDTH-1:0]  r_wr_status;
  logic [ADDR_WIDTH-1:0]    r_src_addr;
  logic [ADDR_WIDTH-1:0]    r_des_addr;
  logic [SIZE_WIDTH-1:0]    r_src_size;
  logic [SIZE_WIDTH-1:0]    r_des_size;
  logic                     w_last;
  logic                     w_abort_any;
  logic                     w_finish;

  assign w_count_clamped = (slot_count > SLOTS) ? SLOTS : slot_count;
  assign w_last          = ({1'b0, r_idx} == (r_count - 1'b1));
  // An abort arriving in the NEXT cycle itself still ends the run there.
  assign w_abort_any     = r_abort | abort;
  assign w_finish        = w_last | w_abort_any;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && (slot_count != '0)) w_next = S_FETCH;
      S_FETCH: w_next = (rd_status == ST_READY) ? S_ISSUE : S_NEXT;
      S_ISSUE: if (cmd_ready) w_next = S_WAIT;
      S_WAIT:  if (dma_done) w_next = S_WB;
      S_WB:    w_next = S_NEXT;
      S_NEXT:  w_next = w_finish ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_count     <= '0;
      r_abort     <= 1'b0;
      r_zero_done <= 1'b0;
      r_profile   <= '0;
      r_wr_status <= '0;
      r_src_addr  <= '0;
      r_des_addr  <= '0;
      r_src_size  <= '0;
      r_des_size  <= '0;
    end else begin
      r_state     <= w_next;
      r_zero_done <= (r_state == S_IDLE) && start && (slot_count == '0);

      if (r_state == S_NEXT && w_finish) begin
        r_abort <= 1'b0;
      end else if (r_state != S_IDLE && abort) begin
        r_abort <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start && (slot_count != '0)) begin
            r_count <= w_count_clamped;
            r_idx   <= '0;
          end
        end
        S_FETCH: begin
          if (rd_status == ST_READY) begin
            r_src_addr <= rd_src_addr;
            r_des_addr <= rd_des_addr;
            r_src_size <= rd_src_size;
            r_des_size <= rd_des_size;
            r_profile  <= '0;
          end
        end
        S_ISSUE: begin
          if (r_profile != '1) r_profile <= r_profile + 1'b1;
        end
        S_WAIT: begin
          if (r_profile != '1) r_profile <= r_profile + 1'b1;
          if (dma_done) r_wr_status <= dma_err ? ST_ERROR : ST_DONE;
        end
        S_NEXT: begin
          if (!w_finish) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_index     = r_idx;
  assign wr_index     = r_idx;
  assign wr_status    = r_wr_status;
  assign wr_profile   = r_profile;
  assign set_status   = (r_state == S_WB);
  assign set_profile  = (r_state == S_WB);
  assign cmd_valid    = (r_state == S_ISSUE);
  assign cmd_src_addr = r_src_addr;
  assign cmd_des_addr = r_des_addr;
  assign cmd_src_size = r_src_size;
  assign cmd_des_size = r_des_size;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_zero_done | ((r_state == S_NEXT) && w_finish);
  assign aborted      = (r_state == S_NEXT) && w_finish && w_abort_any;

endmodule

// File: tb/tb_slot_dispatcher.sv
// Directed bench for slot_dispatcher: slot-table model, DMA responder, write-back
// monitor, a table of single-run vectors and hand sequences for abort/reset/restart.
module tb_slot_dispatcher;
  localparam int IW  = 2;
  localparam int AW  = 32;
  localparam int SW  = 26;
  localparam int STW = 2;
  localparam int PW  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW:0]   slot_count = '0;
  logic          cmd_ready = 1'b0;
  logic          dma_done = 1'b0;
  logic          dma_err = 1'b0;
  logic [IW-1:0] rd_index, wr_index;
  logic [AW-1:0] rd_src_addr, rd_des_addr, cmd_src_addr, cmd_des_addr;
  logic [SW-1:0] rd_src_size, rd_des_size, cmd_src_size, cmd_des_size;
  logic [STW-1:0] rd_status, wr_status;
  logic [PW-1:0] wr_profile;
  logic          set_status, set_profile, cmd_valid, busy, done, aborted;

  logic [AW-1:0]  t_src [4];
  logic [AW-1:0]  t_des [4];
  logic [SW-1:0]  t_ssz [4];
  logic [SW-1:0]  t_dsz [4];
  logic [STW-1:0] t_st  [4];

  assign rd_src_addr = t_src[rd_index];
  assign rd_des_addr = t_des[rd_index];
  assign rd_src_size = t_ssz[rd_index];
  assign rd_des_size = t_dsz[rd_index];
  assign rd_status   = t_st[rd_index];

  slot_dispatcher #(
    .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
    .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .slot_count(slot_count), .abort(abort),
    .rd_index(rd_index), .rd_src_addr(rd_src_addr), .rd_des_addr(rd_des_addr),
    .rd_src_size(rd_src_size), .rd_des_size(rd_des_size), .rd_status(rd_status),
    .wr_index(wr_index), .wr_status(wr_status), .wr_profile(wr_profile),
    .set_status(set_status), .set_profile(set_profile),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_des_addr(cmd_des_addr),
    .cmd_src_size(cmd_src_size), .cmd_des_size(cmd_des_size),
    .dma_done(dma_done), .dma_err(dma_err),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DMA responder: ready after cfg_rdly stalled ISSUE cycles, done after cfg_ddly WAIT cycles.
  int  cfg_rdly = 0;
  int  cfg_ddly = 0;
  bit  cfg_err [4];
  bit  pending = 1'b0;
  int  issue_cnt = 0;
  int  wait_cnt = 0;
  logic [IW-1:0] pend_idx = '0;

  initial forever begin
    @(negedge clk);
    if (reset && cmd_valid && cmd_ready) begin
      pending  = 1'b1;
      wait_cnt = 0;
      pend_idx = rd_index;
    end
    @(posedge clk);
    #1;
    if (cmd_valid) begin
      cmd_ready = (issue_cnt >= cfg_rdly);
      issue_cnt++;
    end else begin
      cmd_ready = 1'b0;
      issue_cnt = 0;
    end
    if (dma_done) begin
      dma_done = 1'b0;
      dma_err  = 1'b0;
      pending  = 1'b0;
    end else if (pending) begin
      if (wait_cnt >= cfg_ddly) begin
        dma_done = 1'b1;
        dma_err  = cfg_err[pend_idx];
      end
      wait_cnt++;
    end
  end

  int n_hs = 0, n_wr = 0, n_done = 0, done_cyc = 0;
  bit done_abt = 1'b0;
  int stab_err = 0, cmd_err = 0, pair_err = 0;
  int busy_at [4];
  int hs_q [$];
  int wr_idx_q [$];
  int wr_st_q [$];
  longint wr_prof_q [$];
  bit p_v = 1'b0, p_r = 1'b0;
  logic [AW-1:0] p_src, p_des;
  logic [SW-1:0] p_ssz, p_dsz;

  always @(negedge clk) begin
    if (!reset) begin
      p_v = 1'b0;
    end else begin
      if (p_v && !p_r && (!cmd_valid || cmd_src_addr != p_src || cmd_des_addr != p_des ||
                          cmd_src_size != p_ssz || cmd_des_size != p_dsz))
        stab_err++;
      p_v = cmd_valid; p_r = cmd_ready;
      p_src = cmd_src_addr; p_des = cmd_des_addr; p_ssz = cmd_src_size; p_dsz = cmd_des_size;
      if (cmd_valid && cmd_ready) begin
        n_hs++;
        hs_q.push_back(int'(rd_index));
        if (cmd_src_addr != t_src[rd_index] || cmd_des_addr != t_des[rd_index] ||
            cmd_src_size != t_ssz[rd_index] || cmd_des_size != t_dsz[rd_index])
          cmd_err++;
      end
      if (set_status || set_profile) begin
        if (set_status != set_profile) pair_err++;
        n_wr++;
        wr_idx_q.push_back(int'(wr_index));
        wr_st_q.push_back(int'(wr_status));
        wr_prof_q.push_back(longint'(wr_profile));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        done_abt = aborted;
      end
      if (busy) busy_at[rd_index]++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int b_hs, b_wr, b_done, b_stab, b_cmd, b_pair, b_hi;

  task automatic snap();
    b_hs = n_hs; b_wr = n_wr; b_done = n_done;
    b_stab = stab_err; b_cmd = cmd_err; b_pair = pair_err;
    b_hi = busy_at[2] + busy_at[3];
  endtask

  // Pulse start for one cycle, then wait (bounded) for the done pulse; lat=-1 on timeout.
  task automatic run(input int cnt, output int lat);
    int t0;
    int bd;
    bd = n_done;
    lat = -1;
    @(posedge clk); #1;
    slot_count = (IW+1)'(cnt);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (n_done != bd) begin
        lat = done_cyc - t0;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int cnt; int st0; int rdly; int ddly; bit err;
    int lat; int hs; int wr; int wst; int prof;
  } vec_t;

  vec_t vecs [8];
  int   lat;

  initial begin
    vecs[0] = '{1, 1, 0, 0, 1'b0, 5, 1, 1, 2, 2};
    vecs[1] = '{1, 1, 3, 0, 1'b0, 8, 1, 1, 2, 5};
    vecs[2] = '{1, 1, 0, 2, 1'b1, 7, 1, 1, 3, 4};
    vecs[3] = '{1, 0, 0, 0, 1'b0, 2, 0, 0, 0, 0};
    vecs[4] = '{1, 2, 0, 0, 1'b0, 2, 0, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 0, 1'b0, 1, 0, 0, 0, 0};
    vecs[6] = '{2, 1, 0, 0, 1'b0, 7, 1, 1, 2, 2};
    vecs[7] = '{7, 0, 0, 0, 1'b0, 8, 0, 0, 0, 0};

    for (int i = 0; i < 4; i++) begin
      t_src[i] = AW'(32'hA000_0000 + i * 32'h100);
      t_des[i] = AW'(32'hB000_0000 + i * 32'h240);
      t_ssz[i] = SW'(32'h40 + i * 32'h11);
      t_dsz[i] = SW'(32'h80 + i * 32'h23);
      t_st[i]  = '0;
      cfg_err[i] = 1'b0;
      busy_at[i] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_done", done, 0);
    check("rst_set_status", set_status, 0);
    check("rst_rd_index", rd_index, 0);
    check("rst_wr_profile", wr_profile, 0);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      t_st[0] = STW'(vecs[v].st0);
      for (int k = 1; k < 4; k++) t_st[k] = '0;
      cfg_err[0] = vecs[v].err;
      cfg_rdly = vecs[v].rdly;
      cfg_ddly = vecs[v].ddly;
      snap();
      run(vecs[v].cnt, lat);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_aborted", v), done_abt, 0);
      check($sformatf("v%0d_handshakes", v), n_hs - b_hs, vecs[v].hs);
      check($sformatf("v%0d_writebacks", v), n_wr - b_wr, vecs[v].wr);
      check($sformatf("v%0d_cmd_stable", v), stab_err - b_stab, 0);
      check($sformatf("v%0d_cmd_fields", v), cmd_err - b_cmd, 0);
      if (vecs[v].wr == 1 && n_wr - b_wr == 1) begin
        check($sformatf("v%0d_wr_index", v), wr_idx_q[b_wr], 0);
        check($sformatf("v%0d_wr_status", v), wr_st_q[b_wr], vecs[v].wst);
        check($sformatf("v%0d_wr_profile", v), wr_prof_q[b_wr], vecs[v].prof);
      end
    end

    // Four slots {EMPTY, READY, ERROR, READY}, slot 3 completes with an error.
    t_st[0] = 2'd0; t_st[1] = 2'd1; t_st[2] = 2'd3; t_st[3] = 2'd1;
    cfg_err[0] = 1'b0; cfg_err[3] = 1'b1;
    cfg_rdly = 0; cfg_ddly = 0;
    snap();
    run(4, lat);
    check("mix_latency", lat, 14);
    check("mix_aborted", done_abt, 0);
    check("mix_handshakes", n_hs - b_hs, 2);
    check("mix_writebacks", n_wr - b_wr, 2);
    check("mix_cmd_fields", cmd_err - b_cmd, 0);
    check("mix_pairing", pair_err - b_pair, 0);
    if (n_hs - b_hs == 2) begin
      check("mix_hs0_idx", hs_q[b_hs], 1);
      check("mix_hs1_idx", hs_q[b_hs + 1], 3);
    end
    if (n_wr - b_wr == 2) begin
      check("mix_wr0_idx", wr_idx_q[b_wr], 1);
      check("mix_wr0_status", wr_st_q[b_wr], 2);
      check("mix_wr1_idx", wr_idx_q[b_wr + 1], 3);
      check("mix_wr1_status", wr_st_q[b_wr + 1], 3);
      check("mix_wr1_profile", wr_prof_q[b_wr + 1], 2);
    end
    cfg_err[3] = 1'b0;

    // Abort pulsed while slot 1 is waiting on its transfer.
    for (int k = 0; k < 4; k++) t_st[k] = 2'd1;
    cfg_ddly = 4;
    snap();
    fork
      run(4, lat);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (pending && busy && rd_index == 2'd1) begin
            seen = 1'b1;
            break;
          end
        end
        check("abort_reached_wait", seen, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
      end
    join
    check("abort_latency", lat, 18);
    check("abort_flag", done_abt, 1);
    check("abort_handshakes", n_hs - b_hs, 2);
    check("abort_writebacks", n_wr - b_wr, 2);
    check("abort_no_fetch_2_3", busy_at[2] + busy_at[3] - b_hi, 0);
    if (n_wr - b_wr == 2) check("abort_wr1_idx", wr_idx_q[b_wr + 1], 1);

    // A second start while busy must be ignored.
    for (int k = 0; k < 4; k++) t_st[k] = '0;
    t_st[0] = 2'd1;
    cfg_ddly = 3;
    snap();
    fork
      run(1, lat);
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("busy_start_latency", lat, 8);
    check("busy_start_dones", n_done - b_done, 1);
    check("busy_start_writebacks", n_wr - b_wr, 1);
    check("busy_start_handshakes", n_hs - b_hs, 1);

    // Reset while slot 1 waits on its transfer; the late dma_done must be ignored.
    t_st[0] = 2'd0; t_st[1] = 2'd1;
    cfg_ddly = 6;
    snap();
    @(posedge clk); #1;
    slot_count = 3'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (pending && busy) begin
          seen = 1'b1;
          break;
        end
      end
      check("rst_mid_reached_wait", seen, 1);
    end
    @(posedge clk); #3;
    check("pre_rst_rd_index", rd_index, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_index", rd_index, 0);
    check("mid_rst_wr_profile", wr_profile, 0);
    check("mid_rst_cmd_src", cmd_src_addr, 0);
    check("mid_rst_set_status", set_status, 0);
    check("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_writebacks", n_wr - b_wr, 0);
    check("post_rst_dones", n_done - b_done, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_late_done_seen", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
